// File: rtl/frame_energy_detector_if.sv
// Sample-stream and frame-result bundle for the frame energy detector.
// The master side produces samples and consumes results; the slave side is the detector.
interface frame_energy_detector_if;
    logic        ivalid;
    logic [31:0] iidx;
    logic [15:0] idata;
    logic [31:0] ithresh;
    logic        ovalid;
    logic [31:0] osum;
    logic [31:0] oframe;
    logic [31:0] ostart_idx;
    logic        ospeech;
    logic        odrop;

    modport master (
        output ivalid, iidx, idata, ithresh,
        input  ovalid, osum, oframe, ostart_idx, ospeech, odrop
    );

    modport slave (
        input  ivalid, iidx, idata, ithresh,
        output ovalid, osum, oframe, ostart_idx, ospeech, odrop
    );
endinterface

// File: rtl/frame_energy_detector.sv
// Accumulates saturated magnitude sums over fixed-length frames of contiguous sample
// indices and produces a voice-activity decision with hangover per completed frame.
module frame_energy_detector #(
    parameter int FRAME_LEN = 256,
    parameter int HANGOVER  = 8
) (
    input logic                  iclk,
    input logic                  irstn,
    frame_energy_detector_if.slave bus
);

    localparam int CNT_W = $clog2(FRAME_LEN + 1);

    typedef enum logic {
        EMPTY,
        ACCUM
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        start_q, start_d;
    logic [31:0]        exp_q, exp_d;
    logic [31:0]        frame_ctr_q, frame_ctr_d;
    logic [7:0]         hang_q, hang_d;
    logic               ovalid_q, ovalid_d;
    logic               odrop_q, odrop_d;
    logic [31:0]        osum_q, osum_d;
    logic [31:0]        oframe_q, oframe_d;
    logic [31:0]        ostart_q, ostart_d;
    logic               ospeech_q, ospeech_d;

    logic [32:0]        sum_ext;
    logic [31:0]        sat_sum;
    logic               last_sample;
    logic               restart;

    // The 33rd bit of the widened sum flags overflow, which clamps rather than wraps.
    assign sum_ext     = {1'b0, acc_q} + {17'd0, bus.idata};
    assign sat_sum     = sum_ext[32] ? 32'hFFFF_FFFF : sum_ext[31:0];
    assign last_sample = (cnt_q == CNT_W'(FRAME_LEN - 1));
    assign restart     = (state_q == EMPTY) || (bus.iidx != exp_q);

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        start_d     = start_q;
        exp_d       = exp_q;
        frame_ctr_d = frame_ctr_q;
        hang_d      = hang_q;
        ovalid_d    = 1'b0;
        odrop_d     = 1'b0;
        osum_d      = osum_q;
        oframe_d    = oframe_q;
        ostart_d    = ostart_q;
        ospeech_d   = ospeech_q;

        if (bus.ivalid) begin
            if (restart) begin
                // An index gap while accumulating throws away the partial frame and
                // lets the offending sample open a fresh one.
                odrop_d = (state_q == ACCUM);
                acc_d   = {16'd0, bus.idata};
                cnt_d   = CNT_W'(1);
                start_d = bus.iidx;
                exp_d   = bus.iidx + 32'd1;
                state_d = ACCUM;
            end else if (last_sample) begin
                ovalid_d    = 1'b1;
                osum_d      = sat_sum;
                ostart_d    = start_q;
                oframe_d    = frame_ctr_q;
                frame_ctr_d = frame_ctr_q + 32'd1;
                acc_d       = 32'd0;
                cnt_d       = '0;
                state_d     = EMPTY;
                if (sat_sum >= bus.ithresh) begin
                    ospeech_d = 1'b1;
                    hang_d    = 8'(HANGOVER);
                end else if (hang_q != 8'd0) begin
                    ospeech_d = 1'b1;
                    hang_d    = hang_q - 8'd1;
                end else begin
                    ospeech_d = 1'b0;
                end
            end else begin
                acc_d = sat_sum;
                cnt_d = cnt_q + CNT_W'(1);
                exp_d = exp_q + 32'd1;
            end
        end
    end

    always_ff @(posedge iclk) begin
        if (!irstn) begin
            state_q     <= EMPTY;
            acc_q       <= 32'd0;
            cnt_q       <= '0;
            start_q     <= 32'd0;
            exp_q       <= 32'd0;
            frame_ctr_q <= 32'd0;
            hang_q      <= 8'd0;
            ovalid_q    <= 1'b0;
            odrop_q     <= 1'b0;
            osum_q      <= 32'd0;
            oframe_q    <= 32'd0;
            ostart_q    <= 32'd0;
            ospeech_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            start_q     <= start_d;
            exp_q       <= exp_d;
            frame_ctr_q <= frame_ctr_d;
            hang_q      <= hang_d;
            ovalid_q    <= ovalid_d;
            odrop_q     <= odrop_d;
            osum_q      <= osum_d;
            oframe_q    <= oframe_d;
            ostart_q    <= ostart_d;
            ospeech_q   <= ospeech_d;
        end
    end

    assign bus.ovalid     = ovalid_q;
    assign bus.odrop      = odrop_q;
    assign bus.osum       = osum_q;
    assign bus.oframe     = oframe_q;
    assign bus.ostart_idx = ostart_q;
    assign bus.ospeech    = ospeech_q;

endmodule

// File: doc/frame_energy_detector.md
FRAME_ENERGY_DETECTOR -- requirements
Module: frame_energy_detector

Interface
REQ-001 Parameter FRAME_LEN, default 256, SHALL set samples per frame (legal range 2..65536).
REQ-002 Parameter HANGOVER, default 8, SHALL set frames ospeech stays high after energy falls below threshold (0..255).
REQ-003 iclk  input  1  clock; all state SHALL update on the rising edge.
REQ-004 irstn  input  1  reset: synchronous, active-low.
REQ-005 ivalid  input  1  sample strobe; one sample per cycle when high; gaps allowed.
REQ-006 iidx  input  32  sample index accompanying idata.
REQ-007 idata  input  16  unsigned sample magnitude (upstream absolute-value stage output).
REQ-008 ithresh  input  32  unsigned energy threshold, quasi-static.
REQ-009 ovalid  output  1  one-cycle frame-result strobe.
REQ-010 osum  output  32  saturated frame magnitude sum.
REQ-011 oframe  output  32  frame sequence number.
REQ-012 ostart_idx  output  32  iidx of first sample of the frame.
REQ-013 ospeech  output  1  voice-activity decision, valid with ovalid, held until next result.
REQ-014 odrop  output  1  one-cycle strobe: partial frame discarded.

Function
REQ-015 Two states SHALL exist: EMPTY (no samples held) and ACCUM (1..FRAME_LEN-1 samples held).
REQ-016 EMPTY + ivalid: acc=idata, cnt=1, start_idx=iidx, exp_idx=iidx+1 (mod 2^32), go ACCUM.
REQ-017 ACCUM + ivalid + iidx==exp_idx: acc=sat32(acc+idata), cnt++, exp_idx++.
REQ-018 Saturation: sum exceeding 32'hFFFF_FFFF SHALL clamp to 32'hFFFF_FFFF, never wrap.
REQ-019 ACCUM + ivalid + iidx!=exp_idx: partial frame discarded, odrop=1 next cycle, sample treated as EMPTY+ivalid (starts new frame); oframe not incremented.
REQ-020 Sample completing cnt==FRAME_LEN: next cycle ovalid=1, osum=final acc, ostart_idx, oframe=frame_ctr; go EMPTY; frame_ctr++ (wraps 2^32-1 -> 0).
REQ-021 Latency: ovalid SHALL rise exactly 1 cycle after the last sample of a frame's ivalid.
REQ-022 Back-to-back frames with continuous ivalid SHALL lose no samples; first sample of next frame accepted in the same cycle ovalid is asserted.
REQ-023 Decision at completion, ithresh sampled that cycle: sum>=ithresh -> ospeech=1, hang=HANGOVER; else hang>0 -> ospeech=1, hang--; else ospeech=0.
REQ-024 ivalid low SHALL hold all state; no timeout.
REQ-025 Outputs osum, oframe, ostart_idx, ospeech SHALL hold between strobes.
REQ-026 ovalid and odrop SHALL never assert in the same cycle (mismatch only possible in ACCUM; completion leaves EMPTY).

Reset
REQ-027 irstn low at any clock edge SHALL force EMPTY, acc=0, cnt=0, frame_ctr=0, hang=0, ovalid=0, odrop=0, osum=0, oframe=0, ostart_idx=0, ospeech=0.
REQ-028 Reset mid-frame SHALL discard the partial frame without odrop; ivalid during reset ignored.
REQ-029 First frame after reset SHALL report oframe=0.

Verification (FRAME_LEN=4, HANGOVER=2)
REQ-030 Samples 10,20,30,40 at idx 100..103, ithresh=50 -> one cycle later ovalid=1, osum=100, ostart_idx=100, oframe=0, ospeech=1.
REQ-031 Frames sums 100,0,0,0 with ithresh=50 -> ospeech 1,1,1,0; oframe 0..3.
REQ-032 Idx 0,1,5,6,7,8 -> odrop pulse after idx 5; ovalid after idx 8 with ostart_idx=5, oframe=0.
REQ-033 FRAME_LEN=65536, all idata=16'hFFFF -> osum=32'hFFFE_FFFF+..., verify clamp by forcing acc near max: osum=32'hFFFF_FFFF.
REQ-034 irstn low after 2 of 4 samples, then 4 clean samples -> single ovalid, oframe=0, no odrop.
REQ-035 Continuous ivalid 8 samples with ivalid gaps inserted randomly -> two ovalid pulses, sums match reference model, zero samples lost.
